apb_protocol_monitor: RTL and testbench

//  Passive, synthesizable APB3/APB4 protocol checker. Taps the bus between one requester and NUM_SLAVES completers.

---
 rtl/apb_mon_pkg.sv | 32 +++
 rtl/apb_mon_sat_counter.sv | 27 ++
 rtl/apb_protocol_monitor.sv | 155 +++++++++++++++
 tb/tb_apb_protocol_monitor.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/apb_mon_pkg.sv
// Shared types for the APB protocol monitor: FSM phases, violation codes and
// the priority encoder that picks the reported code.
package apb_mon_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } state_e;

   typedef enum logic [3:0] {
      ERR_NONE         = 4'd0,
      ERR_NO_SETUP     = 4'd1,
      ERR_NO_ACCESS    = 4'd2,
      ERR_UNSTABLE     = 4'd3,
      ERR_TIMEOUT      = 4'd4,
      ERR_MULTI_SEL    = 4'd5,
      ERR_STRB_READ    = 4'd6,
      ERR_SLVERR_PHASE = 4'd7
   } err_e;

   localparam int NUM_ERR = 8;

   // Lowest set code wins; bit 0 (NONE) is never a violation.
   function automatic logic [3:0] lowest_err(input logic [NUM_ERR-1:0] v);
      lowest_err = 4'd0;
      for (int i = NUM_ERR - 1; i >= 1; i--) begin
         if (v[i]) lowest_err = 4'(i);
      end
   endfunction

endpackage

// File: rtl/apb_mon_sat_counter.sv
// Saturating event counter; clr takes priority over a same-cycle increment.
module apb_mon_sat_counter #(
   parameter int CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 resetn,
   input  logic                 inc,
   input  logic                 clr,
   output logic [CNT_WIDTH-1:0] count
);

   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr)                         cnt_d = '0;
      else if (inc && (cnt_q != '1))   cnt_d = cnt_q + CNT_WIDTH'(1);
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) cnt_q <= '0;
      else         cnt_q <= cnt_d;
   end

   assign count = cnt_q;

endmodule

// File: rtl/apb_protocol_monitor.sv
// Passive APB3/APB4 protocol checker: phase tracking, stability, select,
// timeout and slverr-phase checks with sticky flags and transfer counters.
module apb_protocol_monitor
   import apb_mon_pkg::*;
#(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int NUM_SLAVES     = 1,
   parameter int TIMEOUT_CYCLES = 16,
   parameter int CNT_WIDTH      = 16
) (
   input  logic                    clk,
   input  logic                    resetn,
   input  logic [NUM_SLAVES-1:0]   psel,
   input  logic                    penable,
   input  logic [ADDR_WIDTH-1:0]   paddr,
   input  logic                    pwrite,
   input  logic [DATA_WIDTH-1:0]   pwdata,
   input  logic [DATA_WIDTH/8-1:0] pstrb,
   input  logic [2:0]              pprot,
   input  logic                    pready,
   input  logic                    pslverr,
   input  logic                    clr,
   output logic                    xfer_done,
   output logic                    err_valid,
   output logic [3:0]              err_code,
   output logic [NUM_ERR-1:0]      err_sticky,
   output logic [CNT_WIDTH-1:0]    wr_count,
   output logic [CNT_WIDTH-1:0]    rd_count,
   output logic [CNT_WIDTH-1:0]    slverr_count
);

   localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);

   state_e                  state_q, state_d;
   logic [WAIT_W-1:0]       wait_q, wait_d;
   logic [ADDR_WIDTH-1:0]   cap_addr_q, cap_addr_d;
   logic                    cap_write_q, cap_write_d;
   logic [DATA_WIDTH-1:0]   cap_wdata_q, cap_wdata_d;
   logic [DATA_WIDTH/8-1:0] cap_strb_q, cap_strb_d;
   logic [2:0]              cap_prot_q, cap_prot_d;
   logic [NUM_SLAVES-1:0]   cap_sel_q, cap_sel_d;
   logic                    xfer_done_q, err_valid_q;
   logic [3:0]              err_code_q;
   logic [NUM_ERR-1:0]      sticky_q, err_vec;
   logic                    sel, multi_sel, mismatch, complete, capture;

   assign sel       = |psel;
   assign multi_sel = (psel & (psel - NUM_SLAVES'(1))) != '0;
   assign mismatch  = (paddr != cap_addr_q) || (pwrite != cap_write_q) ||
                      (pstrb != cap_strb_q) || (pprot != cap_prot_q) ||
                      (psel != cap_sel_q) || (cap_write_q && (pwdata != cap_wdata_q));

   always_comb begin
      state_d  = state_q;
      wait_d   = wait_q;
      err_vec  = '0;
      complete = 1'b0;
      capture  = 1'b0;
      case (state_q)
         IDLE: begin
            if (sel && !penable) begin
               state_d = SETUP;
               capture = 1'b1;
            end else if (sel && penable) begin
               err_vec[ERR_NO_SETUP] = 1'b1;
            end
         end
         SETUP: begin
            wait_d = '0;
            if (!cap_write_q && (cap_strb_q != '0)) err_vec[ERR_STRB_READ] = 1'b1;
            if (!penable || !sel) begin
               err_vec[ERR_NO_ACCESS] = 1'b1;
               state_d = IDLE;
            end else begin
               state_d = ACCESS;
            end
         end
         ACCESS: begin
            if (mismatch || !penable) err_vec[ERR_UNSTABLE] = 1'b1;
            if (pready) begin
               complete = 1'b1;
               if (sel && !penable) begin
                  state_d = SETUP;
                  capture = 1'b1;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               wait_d = wait_q + WAIT_W'(1);
               if (wait_d == WAIT_W'(TIMEOUT_CYCLES)) begin
                  err_vec[ERR_TIMEOUT] = 1'b1;
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      if (multi_sel) err_vec[ERR_MULTI_SEL] = 1'b1;
      if (pslverr && !((state_q == ACCESS) && pready)) err_vec[ERR_SLVERR_PHASE] = 1'b1;

      cap_addr_d  = capture ? paddr  : cap_addr_q;
      cap_write_d = capture ? pwrite : cap_write_q;
      cap_wdata_d = capture ? pwdata : cap_wdata_q;
      cap_strb_d  = capture ? pstrb  : cap_strb_q;
      cap_prot_d  = capture ? pprot  : cap_prot_q;
      cap_sel_d   = capture ? psel   : cap_sel_q;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q     <= IDLE;
         wait_q      <= '0;
         cap_addr_q  <= '0;
         cap_write_q <= 1'b0;
         cap_wdata_q <= '0;
         cap_strb_q  <= '0;
         cap_prot_q  <= '0;
         cap_sel_q   <= '0;
         xfer_done_q <= 1'b0;
         err_valid_q <= 1'b0;
         err_code_q  <= '0;
         sticky_q    <= '0;
      end else begin
         state_q     <= state_d;
         wait_q      <= wait_d;
         cap_addr_q  <= cap_addr_d;
         cap_write_q <= cap_write_d;
         cap_wdata_q <= cap_wdata_d;
         cap_strb_q  <= cap_strb_d;
         cap_prot_q  <= cap_prot_d;
         cap_sel_q   <= cap_sel_d;
         xfer_done_q <= complete;
         err_valid_q <= |err_vec;
         err_code_q  <= lowest_err(err_vec);
         sticky_q    <= clr ? '0 : (sticky_q | err_vec);
      end
   end

   apb_mon_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_wr_cnt (
      .clk(clk), .resetn(resetn), .inc(complete && cap_write_q), .clr(clr), .count(wr_count)
   );
   apb_mon_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_rd_cnt (
      .clk(clk), .resetn(resetn), .inc(complete && !cap_write_q), .clr(clr), .count(rd_count)
   );
   apb_mon_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_slverr_cnt (
      .clk(clk), .resetn(resetn), .inc(complete && pslverr), .clr(clr), .count(slverr_count)
   );

   assign xfer_done  = xfer_done_q;
   assign err_valid  = err_valid_q;
   assign err_code   = err_code_q;
   assign err_sticky = sticky_q;

endmodule

// File: tb/tb_apb_protocol_monitor.sv
// Directed bench for apb_protocol_monitor: legal transfers, each violation
// class, saturation, clear priority and asynchronous reset.
module tb_apb_protocol_monitor;
   import apb_mon_pkg::*;

   localparam int AW = 32, DW = 32, NS = 2, TO = 4, CW = 3;

   logic          clk = 1'b0;
   logic          resetn;
   logic [NS-1:0] psel;
   logic          penable, pwrite, pready, pslverr, clr;
   logic [AW-1:0] paddr;
   logic [DW-1:0] pwdata;
   logic [DW/8-1:0] pstrb;
   logic [2:0]    pprot;
   logic          xfer_done, err_valid;
   logic [3:0]    err_code;
   logic [7:0]    err_sticky;
   logic [CW-1:0] wr_count, rd_count, slverr_count;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   apb_protocol_monitor #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_SLAVES(NS),
      .TIMEOUT_CYCLES(TO), .CNT_WIDTH(CW)
   ) dut (
      .clk(clk), .resetn(resetn), .psel(psel), .penable(penable), .paddr(paddr),
      .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
      .pready(pready), .pslverr(pslverr), .clr(clr),
      .xfer_done(xfer_done), .err_valid(err_valid), .err_code(err_code),
      .err_sticky(err_sticky), .wr_count(wr_count), .rd_count(rd_count),
      .slverr_count(slverr_count)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_ev(input string tag, input logic xd, input logic ev, input logic [3:0] ec);
      chk({tag, ".xfer_done"}, 32'(xfer_done), 32'(xd));
      chk({tag, ".err_valid"}, 32'(err_valid), 32'(ev));
      if (ev) chk({tag, ".err_code"}, 32'(err_code), 32'(ec));
   endtask

   task automatic bus_idle();
      psel = '0; penable = 1'b0; pready = 1'b0; pslverr = 1'b0; clr = 1'b0;
   endtask

   task automatic setup_phase(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                              input logic [3:0] strb);
      psel = 2'b01; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data;
      pstrb = strb; pprot = 3'd0; pready = 1'b0; pslverr = 1'b0; clr = 1'b0;
   endtask

   // Setup edge, enable edge (monitor SETUP), completing edge (monitor ACCESS).
   task automatic do_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                          input logic slverr, input logic clr_done);
      setup_phase(wr, addr, data, wr ? 4'hF : 4'h0);
      tick();
      penable = 1'b1;
      tick();
      pready = 1'b1; pslverr = slverr; clr = clr_done;
      tick();
      clr = 1'b0;
   endtask

   initial begin
      resetn = 1'b0; bus_idle();
      pwrite = 1'b0; paddr = '0; pwdata = '0; pstrb = '0; pprot = '0;
      tick(); tick();
      chk("rst.xfer_done", 32'(xfer_done), 32'd0);
      chk("rst.err_valid", 32'(err_valid), 32'd0);
      chk("rst.err_code", 32'(err_code), 32'd0);
      chk("rst.sticky", 32'(err_sticky), 32'd0);
      chk("rst.counts", {8'd0, 5'd0, wr_count, 5'd0, rd_count, 5'd0, slverr_count}, 32'd0);
      chk("rst.state", 32'(dut.state_q), 32'(IDLE));
      resetn = 1'b1;

      // Write 0x10 <- 0xA5 with two wait states
      setup_phase(1'b1, 32'h10, 32'hA5, 4'hF);
      tick(); chk_ev("wr.setup", 1'b0, 1'b0, 4'd0);
      penable = 1'b1;
      tick(); chk_ev("wr.enable", 1'b0, 1'b0, 4'd0);
      tick(); chk_ev("wr.wait1", 1'b0, 1'b0, 4'd0);
      tick(); chk_ev("wr.wait2", 1'b0, 1'b0, 4'd0);
      pready = 1'b1;
      tick(); chk_ev("wr.done", 1'b1, 1'b0, 4'd0);
      chk("wr.wr_count", 32'(wr_count), 32'd1);
      bus_idle();
      tick(); chk_ev("wr.after", 1'b0, 1'b0, 4'd0);

      // Back-to-back read then write
      setup_phase(1'b0, 32'h20, 32'h0, 4'h0);
      tick(); penable = 1'b1;
      tick(); pready = 1'b1;
      tick(); chk_ev("b2b.rd", 1'b1, 1'b0, 4'd0);
      chk("b2b.rd_count", 32'(rd_count), 32'd1);
      setup_phase(1'b1, 32'h24, 32'h5A, 4'hF);
      tick(); chk("b2b.state_setup", 32'(dut.state_q), 32'(SETUP));
      chk_ev("b2b.wr_setup", 1'b0, 1'b0, 4'd0);
      penable = 1'b1;
      tick(); chk("b2b.state_access", 32'(dut.state_q), 32'(ACCESS));
      pready = 1'b1;
      tick(); chk_ev("b2b.wr", 1'b1, 1'b0, 4'd0);
      chk("b2b.wr_count", 32'(wr_count), 32'd2);
      chk("b2b.rd_count2", 32'(rd_count), 32'd1);
      bus_idle(); tick();

      // Address changes 0x10 -> 0x14 during ACCESS
      setup_phase(1'b0, 32'h10, 32'h0, 4'h0);
      tick(); penable = 1'b1;
      tick(); paddr = 32'h14;
      tick(); chk_ev("unst", 1'b0, 1'b1, 4'd3);
      chk("unst.sticky3", 32'(err_sticky[3]), 32'd1);
      pready = 1'b1;
      tick(); chk_ev("unst.done", 1'b1, 1'b1, 4'd3);
      bus_idle();
      tick(); chk_ev("unst.after", 1'b0, 1'b0, 4'd0);

      // Timeout after four ACCESS wait edges
      setup_phase(1'b1, 32'h30, 32'h11, 4'hF);
      tick(); penable = 1'b1;
      tick();
      tick(); chk_ev("to.w1", 1'b0, 1'b0, 4'd0);
      tick(); chk_ev("to.w2", 1'b0, 1'b0, 4'd0);
      tick(); chk_ev("to.w3", 1'b0, 1'b0, 4'd0);
      tick(); chk_ev("to.w4", 1'b0, 1'b1, 4'd4);
      chk("to.state", 32'(dut.state_q), 32'(IDLE));
      bus_idle();
      tick(); chk_ev("to.after", 1'b0, 1'b0, 4'd0);

      // Double select with pslverr in the setup cycle
      setup_phase(1'b1, 32'h50, 32'h0, 4'hF);
      psel = 2'b11; pslverr = 1'b1;
      tick(); chk_ev("msel", 1'b0, 1'b1, 4'd5);
      chk("msel.sticky", 32'(err_sticky), 32'hB8);
      psel = 2'b00; pslverr = 1'b0;
      tick(); chk_ev("noacc", 1'b0, 1'b1, 4'd2);
      chk("noacc.sticky", 32'(err_sticky), 32'hBC);

      // Read with strobes set, then enable without setup
      setup_phase(1'b0, 32'h60, 32'h0, 4'h1);
      tick(); chk_ev("strb.setup", 1'b0, 1'b0, 4'd0);
      penable = 1'b1;
      tick(); chk_ev("strb", 1'b0, 1'b1, 4'd6);
      pready = 1'b1;
      tick(); chk_ev("strb.done", 1'b1, 1'b0, 4'd0);
      chk("strb.rd_count", 32'(rd_count), 32'd3);
      pready = 1'b0;
      tick(); chk_ev("nosetup", 1'b0, 1'b1, 4'd1);
      bus_idle();
      tick(); chk("all.sticky", 32'(err_sticky), 32'hFE);
      clr = 1'b1;
      tick(); clr = 1'b0;
      chk("clr.sticky", 32'(err_sticky), 32'd0);
      chk("clr.wr_count", 32'(wr_count), 32'd0);
      chk("clr.rd_count", 32'(rd_count), 32'd0);

      // Saturation at 7, then clear together with a completion
      for (int i = 0; i < 7; i++) do_xfer(1'b1, 32'h100 + 32'(i), 32'h1000 + 32'(i), 1'b1, 1'b0);
      chk("sat.wr7", 32'(wr_count), 32'd7);
      chk("sat.slv7", 32'(slverr_count), 32'd7);
      do_xfer(1'b1, 32'h200, 32'h2, 1'b1, 1'b0);
      chk_ev("sat.extra", 1'b1, 1'b0, 4'd0);
      chk("sat.wr_hold", 32'(wr_count), 32'd7);
      chk("sat.slv_hold", 32'(slverr_count), 32'd7);
      do_xfer(1'b1, 32'h204, 32'h3, 1'b1, 1'b1);
      chk_ev("clrdone", 1'b1, 1'b0, 4'd0);
      chk("clrdone.wr", 32'(wr_count), 32'd0);
      chk("clrdone.slv", 32'(slverr_count), 32'd0);

      // Asynchronous reset in the middle of ACCESS
      do_xfer(1'b1, 32'h300, 32'h7, 1'b0, 1'b0);
      chk("prerst.wr", 32'(wr_count), 32'd1);
      setup_phase(1'b0, 32'h40, 32'h0, 4'h0);
      tick(); penable = 1'b1;
      tick(); paddr = 32'h44;
      tick(); chk_ev("prerst.err", 1'b0, 1'b1, 4'd3);
      #2 resetn = 1'b0;
      #1;
      chk("arst.xfer_done", 32'(xfer_done), 32'd0);
      chk("arst.err_valid", 32'(err_valid), 32'd0);
      chk("arst.err_code", 32'(err_code), 32'd0);
      chk("arst.sticky", 32'(err_sticky), 32'd0);
      chk("arst.wr", 32'(wr_count), 32'd0);
      chk("arst.state", 32'(dut.state_q), 32'(IDLE));
      bus_idle();
      tick(); resetn = 1'b1;
      tick(); chk_ev("arst.after", 1'b0, 1'b0, 4'd0);
      chk("arst.state2", 32'(dut.state_q), 32'(IDLE));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
